// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter slice.
package regfile_arb_pkg;

    localparam int NUM_REQ_DEF  = 4;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 64;
    localparam int READ_LAT_DEF = 1;

    // Index width for a requester count, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Bundle between the operand-fetch clients, the read mux and the arbiter.
//
// Handshake: a requester raises req[i] with addr slot i and holds both
// stable until it observes gnt[i]=1 for one cycle. If req[i] is still high
// at the edge that ends the grant cycle, that is a fresh request. The read
// data comes back as a one-cycle rsp_valid[i] pulse with rsp_data exactly
// READ_LAT cycles after gnt[i]; there is no back-pressure on the response.
// rf_stall high blocks new grants only; reads already granted still return.
interface regfile_read_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic                      rf_stall;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rf_sel;
    logic [DATA_W-1:0]         rf_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;

    // Requester / register-file side.
    modport master (
        output req, addr, rf_stall, rf_data,
        input  gnt, rf_sel, rsp_valid, rsp_data, busy
    );

    // Arbiter side.
    modport slave (
        input  req, addr, rf_stall, rf_data,
        output gnt, rf_sel, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin picker: pointer register plus rotate-priority search.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_next,
    output logic [IDX_W-1:0]   index
);

    localparam logic [IDX_W:0]   NUM_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;
    logic             found;

    // Search from the pointer upward, wrapping, for the first requester.
    always_comb begin
        grant_next = '0;
        index      = '0;
        found      = 1'b0;
        cand       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(off);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
        if (en && found) begin
            grant_next[index] = 1'b1;
        end
    end

    // Winner moves to lowest priority; pointer holds when nobody wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (index == LAST) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the register-file read mux among NUM_REQ operand-fetch clients:
// registered grant and select, a one-hot tag pipeline READ_LAT deep, and
// response capture when a tag reaches the end of the pipeline.
module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_read_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]          grant_next;
    logic [IDX_W-1:0]            win_idx;
    logic [ADDR_W-1:0]           win_addr;
    logic [NUM_REQ-1:0]          gnt_q;
    logic [ADDR_W-1:0]           sel_q;
    logic [READ_LAT*NUM_REQ-1:0] tag_sr;
    logic [NUM_REQ-1:0]          tag_tail_in;
    logic [DATA_W-1:0]           rsp_data_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.req),
        .en         (~bus.rf_stall),
        .grant_next (grant_next),
        .index      (win_idx)
    );

    // Register number of the current winner.
    always_comb begin
        win_addr = bus.addr[win_idx*ADDR_W +: ADDR_W];
    end

    // Grant pulse every cycle; select only moves when there is a winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q <= '0;
            sel_q <= '0;
        end else begin
            gnt_q <= grant_next;
            if (|grant_next) begin
                sel_q <= win_addr;
            end
        end
    end

    // Tag pipeline: stage 0 follows gnt, last stage is the response pulse.
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign tag_tail_in = gnt_q;
            // Single stage holds the grant seen in the previous cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag_sr <= '0;
                end else begin
                    tag_sr <= gnt_q;
                end
            end
        end else begin : g_latn
            assign tag_tail_in = tag_sr[(READ_LAT-2)*NUM_REQ +: NUM_REQ];
            // Shift grants toward the response end one stage per cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tag_sr <= '0;
                end else begin
                    tag_sr <= {tag_sr[(READ_LAT-1)*NUM_REQ-1:0], gnt_q};
                end
            end
        end
    endgenerate

    // Capture mux data only at the edge where a tag emerges; hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data_q <= '0;
        end else if (|tag_tail_in) begin
            rsp_data_q <= bus.rf_data;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rf_sel    = sel_q;
    assign bus.rsp_valid = tag_sr[(READ_LAT-1)*NUM_REQ +: NUM_REQ];
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (|gnt_q) | (|tag_sr);

    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.gnt));

    a_rsp_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(bus.rsp_valid));

    a_no_gnt_after_stall : assert property (@(posedge clk) disable iff (reset)
        bus.rf_stall |=> (bus.gnt == '0));

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: READ_LAT=1 and READ_LAT=3 instances share
// one stimulus stream and are checked against a transaction-level model.
module tb_regfile_read_arbiter;
    import regfile_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
    regfile_read_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

    regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    regfile_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    logic [N-1:0]    req_drv;
    logic [AW-1:0]   addr_drv [N];
    logic            stall_drv;
    logic [N*AW-1:0] addr_flat;
    logic [DW-1:0]   regs [32];

    always_comb begin
        addr_flat = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW] = addr_drv[i];
        end
    end

    assign bus1.req      = req_drv;
    assign bus1.addr     = addr_flat;
    assign bus1.rf_stall = stall_drv;
    assign bus3.req      = req_drv;
    assign bus3.addr     = addr_flat;
    assign bus3.rf_stall = stall_drv;

    // Register file read mux: combinational for latency 1, two-stage for 3.
    logic [AW-1:0] sel_d1 = '0;
    logic [AW-1:0] sel_d2 = '0;
    always @(posedge clk) begin
        sel_d1 <= bus3.rf_sel;
        sel_d2 <= sel_d1;
    end
    assign bus1.rf_data = regs[bus1.rf_sel];
    assign bus3.rf_data = regs[sel_d2];

    // ---------------- reference model ----------------
    typedef struct {
        int            inst;
        int            gcyc;
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           exp_q[$];
    int            lat_of [2] = '{1, 3};
    int            ptr_m;
    int            cyc;
    logic [N-1:0]  exp_gnt  [2];
    logic [AW-1:0] exp_sel  [2];
    logic [N-1:0]  exp_rv   [2];
    logic [DW-1:0] exp_rd   [2];
    logic          exp_busy [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ptr_m = 0;
        for (int m = 0; m < 2; m++) begin
            exp_gnt[m]  = '0;
            exp_sel[m]  = '0;
            exp_rv[m]   = '0;
            exp_rd[m]   = '0;
            exp_busy[m] = 1'b0;
        end
    endtask

    // One clock edge of behaviour, using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] g;
        int win;
        int c;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        g = '0;
        if (!stall_drv && req_drv != '0) begin
            win = -1;
            for (int off = 0; off < N; off++) begin
                c = (ptr_m + off) % N;
                if (win < 0 && ((req_drv >> c) & N'(1)) != '0) win = c;
            end
            g     = N'(1) << win;
            ptr_m = (win + 1) % N;
            for (int m = 0; m < 2; m++) begin
                exp_sel[m] = addr_drv[win];
                exp_q.push_back('{m, cyc, cyc + lat_of[m], win, regs[addr_drv[win]]});
            end
        end
        for (int m = 0; m < 2; m++) begin
            exp_gnt[m] = g;
            exp_rv[m]  = '0;
        end
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].due < cyc) exp_q.delete(k);
        end
        for (int m = 0; m < 2; m++) exp_busy[m] = 1'b0;
        foreach (exp_q[k]) begin
            exp_busy[exp_q[k].inst] = 1'b1;
            if (exp_q[k].due == cyc) begin
                exp_rv[exp_q[k].inst] = exp_rv[exp_q[k].inst] | (N'(1) << exp_q[k].idx);
                exp_rd[exp_q[k].inst] = exp_q[k].data;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("gnt_l1",      64'(bus1.gnt),       64'(exp_gnt[0]));
        check_eq("rf_sel_l1",   64'(bus1.rf_sel),    64'(exp_sel[0]));
        check_eq("rsp_valid_l1",64'(bus1.rsp_valid), 64'(exp_rv[0]));
        check_eq("rsp_data_l1", bus1.rsp_data,       exp_rd[0]);
        check_eq("busy_l1",     64'(bus1.busy),      64'(exp_busy[0]));
        check_eq("gnt_l3",      64'(bus3.gnt),       64'(exp_gnt[1]));
        check_eq("rf_sel_l3",   64'(bus3.rf_sel),    64'(exp_sel[1]));
        check_eq("rsp_valid_l3",64'(bus3.rsp_valid), 64'(exp_rv[1]));
        check_eq("rsp_data_l3", bus3.rsp_data,       exp_rd[1]);
        check_eq("busy_l3",     64'(bus3.busy),      64'(exp_busy[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // A requester that sees its grant drops its request.
    task automatic drop_granted();
        req_drv = req_drv & ~exp_gnt[0];
    endtask

    // Asynchronous reset pulse entirely between two clock edges.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        check_eq("areset_gnt",   64'(bus1.gnt | bus3.gnt),             64'(0));
        check_eq("areset_rv",    64'(bus1.rsp_valid | bus3.rsp_valid), 64'(0));
        check_eq("areset_rd",    bus1.rsp_data | bus3.rsp_data,        64'(0));
        check_eq("areset_sel",   64'(bus1.rf_sel | bus3.rf_sel),       64'(0));
        check_eq("areset_busy",  64'(bus1.busy | bus3.busy),           64'(0));
        model_reset();
        #1 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0;
        for (int r = 0; r < 32; r++) regs[r] = {$urandom, $urandom};
        regs[17] = 64'hDEAD_BEEF_0000_0011;
        req_drv   = '0;
        stall_drv = 1'b0;
        for (int i = 0; i < N; i++) addr_drv[i] = '0;
        model_reset();

        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Single request from requester 2 for register 17.
        addr_drv[2] = 5'd17;
        req_drv     = 4'b0100;
        tick();
        check_eq("single_gnt",  64'(bus1.gnt),    64'(4'b0100));
        check_eq("single_sel",  64'(bus1.rf_sel), 64'(17));
        check_eq("single_busy", 64'(bus1.busy),   64'(1));
        drop_granted();
        tick();
        check_eq("single_rv",   64'(bus1.rsp_valid), 64'(4'b0100));
        check_eq("single_rd",   bus1.rsp_data,       64'hDEAD_BEEF_0000_0011);
        tick();
        check_eq("single_idle", 64'(bus1.busy),   64'(0));
        repeat (3) tick();

        // All four together, held until granted.
        for (int i = 0; i < N; i++) addr_drv[i] = AW'(i + 1);
        req_drv = 4'b1111;
        repeat (4) begin
            tick();
            drop_granted();
        end
        repeat (4) tick();

        // Requesters 0 and 3 held continuously.
        req_drv = 4'b1001;
        repeat (8) tick();
        req_drv = '0;
        repeat (4) tick();

        // Stall with an earlier read in flight.
        addr_drv[0] = 5'd9;
        req_drv     = 4'b0001;
        tick();
        req_drv     = 4'b0010;
        addr_drv[1] = 5'd12;
        stall_drv   = 1'b1;
        repeat (3) begin
            tick();
            check_eq("stall_gnt", 64'(bus1.gnt), 64'(0));
        end
        stall_drv = 1'b0;
        tick();
        check_eq("post_stall_gnt", 64'(bus1.gnt), 64'(4'b0010));
        drop_granted();
        repeat (4) tick();

        // Reset between a grant and its response.
        addr_drv[0] = 5'd31;
        req_drv     = 4'b0001;
        tick();
        req_drv = '0;
        pulse_reset();
        req_drv = 4'b0101;
        tick();
        check_eq("post_reset_gnt", 64'(bus1.gnt), 64'(4'b0001));
        drop_granted();
        repeat (5) tick();

        // Back-to-back grants with random register numbers.
        for (int i = 0; i < N; i++) addr_drv[i] = AW'($urandom_range(0, 31));
        req_drv = 4'b1111;
        repeat (4) begin
            tick();
            drop_granted();
        end
        repeat (5) tick();

        // Random traffic with stalls and one reset.
        for (int it = 0; it < 400; it++) begin
            stall_drv = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_drv[i] && $urandom_range(0, 2) == 0) begin
                    req_drv[i]  = 1'b1;
                    addr_drv[i] = AW'($urandom_range(0, 31));
                end
            end
            tick();
            for (int i = 0; i < N; i++) begin
                if (exp_gnt[0][i]) begin
                    if ($urandom_range(0, 1) == 0) req_drv[i] = 1'b0;
                    else addr_drv[i] = AW'($urandom_range(0, 31));
                end
            end
            if (it == 200) pulse_reset();
        end
        req_drv   = '0;
        stall_drv = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
